clock_divider_bank: RTL and testbench
=====================================

# clock_divider_bank

Multi-channel, runtime-programmable clock divider and tick generator. It is the parametrised successor to the single fixed-divisor slow clock. Each channel divides the system clock by its own divisor and produces two outputs: a 50 %-duty toggled clock or a one-cycle strobe, plus a one-cycle tick. The block sits between the board clock and the slow-rate logic (display refresh, debouncers, blinkers), which then needs one block instead of several fixed dividers.

## Interface

Parameters:
- CHANNELS, default 4: number of independent divider channels (1..16).
- WIDTH, default 25: divisor and counter width in bits.
- DEFAULT_DIV, default 25_000_000: divisor loaded into every channel at reset. Must fit in WIDTH bits.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  CHANNELS  per-channel run enable.
- sync  in  1  one-cycle strobe; re-phases all channels together.
- cfg_wr  in  1  configuration write strobe.
- cfg_ch  in  $clog2(CHANNELS) (min 1)  channel index for the write.
- cfg_div  in  WIDTH  new divisor.
- cfg_mode  in  1  new mode: 0 = toggle, 1 = pulse.
- clk_out  out  CHANNELS  divided clock (toggle mode) or strobe (pulse mode); registered.
- tick  out  CHANNELS  one-cycle pulse at every terminal count; registered.
- pending  out  CHANNELS  1 while a written divisor/mode is waiting to take effect.

## Operation

Per-channel state:
- counter[WIDTH]
- active divisor and active mode
- shadow divisor and shadow mode
- pending flag
- clk_out and tick registers

Effective divisor:
- D = active divisor, except that an active divisor of 0 is treated as 1.
- Terminal count is counter == D-1.

Priority per cycle: reset > sync > cfg_wr > counting.

- **Reset:**
  - counter = 0, active = shadow = DEFAULT_DIV, mode = toggle.
  - pending = 0, clk_out = 0, tick = 0 on all channels.
- **Disabled channel (enable = 0):**
  - counter is held at 0; clk_out and tick are driven 0.
  - A cfg_wr to this channel loads active directly; pending stays 0.
- **Enabled, not terminal:**
  - counter increments; tick = 0.
  - Pulse mode: clk_out = 0. Toggle mode: clk_out holds.
- **Enabled, terminal:**
  - counter goes to 0 and tick = 1 for one cycle.
  - Toggle mode: clk_out inverts. Pulse mode: clk_out = 1 for one cycle.
  - If pending = 1, shadow is copied to active and pending clears.
  - A cfg_wr to this channel in the same cycle bypasses the shadow and loads active directly; pending ends at 0.
- **cfg_wr to an enabled channel, non-terminal cycle:**
  - shadow takes cfg_div/cfg_mode and pending = 1.
  - A second write before the terminal count overwrites the shadow; the last write wins.
- **cfg_ch >= CHANNELS:** the write is ignored.
- **sync:**
  - Every channel: counter = 0, clk_out = 0, tick = 0.
  - Any pending shadow is applied and pending clears.
  - A cfg_wr in the same cycle is applied as well, directly to active.
- **Mode change taking effect in toggle→pulse:** clk_out is forced to 0 on the apply cycle.
- **Counter overflow:** the counter never exceeds D-1. If the divisor was reduced below the current count, the new divisor applies only at the terminal count, so wrap-around beyond D-1 cannot occur.

## Timing

- All outputs are registered. There is no combinational path from any input to any output.
- Steady state with divisor D:
  - tick has period D cycles.
  - Toggle mode: clk_out has period 2·D cycles, high D cycles, low D cycles.
  - Pulse mode: clk_out equals tick.
- Enable rising at edge k (counter = 0): the first tick is at edge k+D. With D = 1, tick is high every cycle from edge k+1.
- Enable falling: clk_out and tick are 0 from the next edge.
- A new divisor affects the period that starts after the next terminal count. If the channel is disabled, it is effective immediately.
- After sync at edge s, all enabled channels tick first at edge s+D_ch, so channels with equal D are phase-aligned.
- After reset deassertion, outputs stay 0 until the first terminal count.

## Test plan

Bench uses CHANNELS = 4, WIDTH = 8, DEFAULT_DIV = 4.

- Reset, then enable = 4'b0001 → ch0 tick on every 4th cycle; clk_out[0] toggles every 4 cycles (period 8); other outputs stay 0.
- Write ch1 div = 3 and mode = pulse while ch1 is disabled, then enable it → pending[1] never sets; clk_out[1] = tick[1] = 1 every 3rd cycle.
- Write ch0 div = 2 mid-period (counter = 1) → pending[0] = 1 until ch0's next terminal count; the next period is 2 cycles; pending clears on that terminal edge.
- Write div = 0 to ch2 and enable it → tick[2] is high every cycle; clk_out[2] toggles every cycle.
- Run ch0 (D = 4) and ch3 (written D = 4) with an offset, then pulse sync → both tick on the same edge 4 cycles later; a cfg_wr with cfg_ch = 5 changes nothing.
- Assert reset mid-count with pending set → next edge: all outputs 0, pending = 0, divisors back to 4.

Source files
------------

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: bank of independent runtime-programmable clock dividers.
// Each channel counts system clocks up to its divisor and emits a one-cycle
// tick at every terminal count, plus either a 50 % toggled clock or a strobe.
// Divisor/mode writes to a running channel are held in a shadow register and
// take effect at the next terminal count so the current period is never cut.
module clock_divider_bank #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 25,
  parameter int DEFAULT_DIV = 25_000_000,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  input  logic                sync,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic                cfg_mode,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

  // Writes addressed past the last channel are dropped for every channel.
  logic cfg_in_range;
  assign cfg_in_range = ({1'b0, cfg_ch} < (CH_W + 1)'(CHANNELS));

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [WIDTH-1:0] count_reg;
      logic [WIDTH-1:0] active_div_reg;
      logic [WIDTH-1:0] shadow_div_reg;
      logic             active_mode_reg;
      logic             shadow_mode_reg;
      logic             pending_reg;
      logic             clk_out_reg;
      logic             tick_reg;

      logic [WIDTH-1:0] last_count;
      logic             wr_hit;
      logic             idle;
      logic             terminal;
      logic             mode_next;

      // A divisor of 0 behaves like 1, so the last count is 0 in both cases.
      assign last_count = (active_div_reg == '0) ? '0 : active_div_reg - WIDTH'(1);
      assign wr_hit     = cfg_wr && cfg_in_range && (cfg_ch == CH_W'(gi));
      // Sync and a disabled channel both park the counter at 0 with outputs low.
      assign idle       = sync || !enable[gi];
      assign terminal   = (count_reg == last_count);
      // Mode that will be active after a terminal-count apply this cycle.
      assign mode_next  = wr_hit      ? cfg_mode :
                          pending_reg ? shadow_mode_reg : active_mode_reg;

      // Per-channel counter, configuration and output state.
      always_ff @(posedge clk) begin
        if (reset) begin
          count_reg       <= '0;
          active_div_reg  <= RESET_DIV;
          shadow_div_reg  <= RESET_DIV;
          active_mode_reg <= 1'b0;
          shadow_mode_reg <= 1'b0;
          pending_reg     <= 1'b0;
          clk_out_reg     <= 1'b0;
          tick_reg        <= 1'b0;
        end else if (idle) begin
          count_reg   <= '0;
          clk_out_reg <= 1'b0;
          tick_reg    <= 1'b0;
          pending_reg <= 1'b0;
          // A direct write outranks a waiting shadow value.
          if (wr_hit) begin
            active_div_reg  <= cfg_div;
            active_mode_reg <= cfg_mode;
          end else if (pending_reg) begin
            active_div_reg  <= shadow_div_reg;
            active_mode_reg <= shadow_mode_reg;
          end
        end else if (terminal) begin
          count_reg   <= '0;
          tick_reg    <= 1'b1;
          pending_reg <= 1'b0;
          if (!active_mode_reg && mode_next) begin
            clk_out_reg <= 1'b0;          // leaving toggle mode: start pulse mode low
          end else if (active_mode_reg) begin
            clk_out_reg <= 1'b1;          // pulse mode strobe
          end else begin
            clk_out_reg <= ~clk_out_reg;  // toggle mode half-period edge
          end
          if (wr_hit) begin
            active_div_reg  <= cfg_div;
            active_mode_reg <= cfg_mode;
          end else if (pending_reg) begin
            active_div_reg  <= shadow_div_reg;
            active_mode_reg <= shadow_mode_reg;
          end
        end else begin
          count_reg <= count_reg + WIDTH'(1);
          tick_reg  <= 1'b0;
          if (active_mode_reg) begin
            clk_out_reg <= 1'b0;
          end
          // Mid-period write: park it until the period completes.
          if (wr_hit) begin
            shadow_div_reg  <= cfg_div;
            shadow_mode_reg <= cfg_mode;
            pending_reg     <= 1'b1;
          end
        end
      end

      assign clk_out[gi] = clk_out_reg;
      assign tick[gi]    = tick_reg;
      assign pending[gi] = pending_reg;
    end
  endgenerate

endmodule

// File: tb/tb_clock_divider_bank.sv
// Testbench for clock_divider_bank: directed scenarios followed by random
// traffic, every cycle compared against a countdown-based reference model.
module tb_clock_divider_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] en;
  logic       sy;
  logic       wr;
  logic [1:0] ch;
  logic [7:0] dv;
  logic       md;
  logic [3:0] clk_out, tick, pending;

  // Second, three-channel instance: cfg_ch = 3 is out of range there.
  logic [2:0] en2;
  logic       wr2;
  logic [1:0] ch2v;
  logic [7:0] dv2;
  logic       md2;
  logic [2:0] clk_out2, tick2, pending2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_divider_bank #(.CHANNELS(4), .WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clk(clk), .reset(rst), .enable(en), .sync(sy), .cfg_wr(wr), .cfg_ch(ch),
    .cfg_div(dv), .cfg_mode(md), .clk_out(clk_out), .tick(tick), .pending(pending)
  );

  clock_divider_bank #(.CHANNELS(3), .WIDTH(8), .DEFAULT_DIV(4)) dut3 (
    .clk(clk), .reset(rst), .enable(en2), .sync(1'b0), .cfg_wr(wr2), .cfg_ch(ch2v),
    .cfg_div(dv2), .cfg_mode(md2), .clk_out(clk_out2), .tick(tick2), .pending(pending2)
  );

  // Reference model: m_rem = cycles left until the next tick of each channel.
  int m_rem [4];
  int m_act [4];
  int m_sh  [4];
  bit m_mode[4];
  bit m_shm [4];
  bit m_pend[4];
  bit m_clk [4];
  bit m_tick[4];

  function automatic int eff(input int a);
    return (a == 0) ? 1 : a;
  endfunction

  task automatic model_step();
    for (int c = 0; c < 4; c++) begin
      bit hit;
      bit old;
      hit = wr && (int'(ch) == c);
      if (rst) begin
        m_act[c] = 4; m_sh[c] = 4; m_mode[c] = 0; m_shm[c] = 0;
        m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0; m_rem[c] = 4;
      end else if (sy || !en[c]) begin
        if (m_pend[c]) begin m_act[c] = m_sh[c]; m_mode[c] = m_shm[c]; end
        if (hit) begin m_act[c] = int'(dv); m_mode[c] = md; end
        m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
        m_rem[c] = eff(m_act[c]);
      end else if (m_rem[c] == 1) begin
        old = m_mode[c];
        if (hit) begin m_act[c] = int'(dv); m_mode[c] = md; end
        else if (m_pend[c]) begin m_act[c] = m_sh[c]; m_mode[c] = m_shm[c]; end
        m_pend[c] = 0;
        m_tick[c] = 1;
        if (!old && m_mode[c]) m_clk[c] = 0;
        else if (old)          m_clk[c] = 1;
        else                   m_clk[c] = !m_clk[c];
        m_rem[c] = eff(m_act[c]);
      end else begin
        m_rem[c] = m_rem[c] - 1;
        m_tick[c] = 0;
        if (m_mode[c]) m_clk[c] = 0;
        if (hit) begin m_sh[c] = int'(dv); m_shm[c] = md; m_pend[c] = 1; end
      end
    end
  endtask

  function automatic logic [3:0] pack(input bit a [4]);
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = a[c];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: DUT and model see the same inputs; compare, then drop strobes.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("model_clk_out", 32'(clk_out), 32'(pack(m_clk)));
    chk("model_tick",    32'(tick),    32'(pack(m_tick)));
    chk("model_pending", 32'(pending), 32'(pack(m_pend)));
    wr = 0; sy = 0; wr2 = 0;
  endtask

  task automatic write_cfg(input logic [1:0] c, input logic [7:0] d, input logic m);
    wr = 1; ch = c; dv = d; md = m;
  endtask

  initial begin
    int guard;
    rst = 1; en = '0; sy = 0; wr = 0; ch = '0; dv = '0; md = 0;
    en2 = '0; wr2 = 0; ch2v = '0; dv2 = '0; md2 = 0;

    // Reset state.
    cyc(); cyc();
    rst = 0;
    chk("reset_clk_out", 32'(clk_out), 0);
    chk("reset_tick",    32'(tick),    0);
    chk("reset_pending", 32'(pending), 0);

    // Out-of-range channel write on the three-channel bank is ignored.
    en2 = 3'b111;
    for (int n = 1; n <= 12; n++) begin
      if (n == 2) begin wr2 = 1; ch2v = 2'd3; dv2 = 8'd2; md2 = 1; end
      cyc();
      chk("oor_pending", 32'(pending2), 0);
      chk("oor_tick",    32'(tick2),    (n % 4 == 0) ? 32'h7 : 32'h0);
      chk("oor_clk_out", 32'(clk_out2), ((n / 4) % 2 == 1) ? 32'h7 : 32'h0);
    end

    // ch0 at the default divisor of 4 in toggle mode.
    en = 4'b0001;
    for (int n = 1; n <= 12; n++) begin
      cyc();
      chk("ch0_tick",    32'(tick[0]),    (n % 4 == 0) ? 1 : 0);
      chk("ch0_clk_out", 32'(clk_out[0]), ((n / 4) % 2 == 1) ? 1 : 0);
      chk("ch0_others",  32'(tick[3:1] | clk_out[3:1]), 0);
    end

    // Disabled write to ch1 takes effect at once: D = 3, pulse mode.
    write_cfg(2'd1, 8'd3, 1'b1);
    cyc();
    chk("ch1_pending_disabled", 32'(pending[1]), 0);
    en = 4'b0011;
    for (int n = 1; n <= 9; n++) begin
      cyc();
      chk("ch1_pending", 32'(pending[1]), 0);
      chk("ch1_tick",    32'(tick[1]),    (n % 3 == 0) ? 1 : 0);
      chk("ch1_pulse",   32'(clk_out[1]), (n % 3 == 0) ? 1 : 0);
    end

    // Mid-period write to running ch0 (counter = 1) waits for terminal count.
    guard = 0;
    while (m_rem[0] != 3 && guard < 10) begin cyc(); guard++; end
    chk("ch0_align_timeout", (guard < 10) ? 1 : 0, 1);
    write_cfg(2'd0, 8'd2, 1'b0);
    cyc();
    chk("ch0_pending_set", 32'(pending[0]), 1);
    guard = 0;
    while (tick[0] !== 1'b1 && guard < 8) begin
      chk("ch0_pending_hold", 32'(pending[0]), 1);
      cyc(); guard++;
    end
    chk("ch0_tick_timeout", (guard < 8) ? 1 : 0, 1);
    chk("ch0_pending_clear", 32'(pending[0]), 0);
    for (int n = 1; n <= 4; n++) begin
      cyc();
      chk("ch0_div2_tick", 32'(tick[0]), (n % 2 == 0) ? 1 : 0);
    end

    // Divisor 0 on ch2 behaves as 1.
    write_cfg(2'd2, 8'd0, 1'b0);
    cyc();
    en = 4'b0111;
    for (int n = 1; n <= 6; n++) begin
      cyc();
      chk("ch2_tick",    32'(tick[2]),    1);
      chk("ch2_clk_out", 32'(clk_out[2]), n % 2);
    end

    // ch0 back to D = 4, ch3 D = 4 with an offset, then sync aligns them.
    write_cfg(2'd0, 8'd4, 1'b0);
    cyc();
    write_cfg(2'd3, 8'd4, 1'b0);
    cyc();
    cyc(); cyc();
    en = 4'b1111;
    cyc(); cyc();
    sy = 1;
    cyc();
    chk("sync_outputs", 32'(tick | clk_out | pending), 0);
    for (int n = 1; n <= 4; n++) begin
      cyc();
      chk("sync_tick0", 32'(tick[0]), (n == 4) ? 1 : 0);
      chk("sync_tick3", 32'(tick[3]), (n == 4) ? 1 : 0);
    end

    // Reset while ch0 has a pending write.
    write_cfg(2'd0, 8'd7, 1'b1);
    cyc();
    chk("pre_reset_pending", 32'(pending[0]), 1);
    rst = 1;
    cyc();
    rst = 0;
    chk("mid_reset_outputs", 32'(tick | clk_out | pending), 0);
    for (int n = 1; n <= 8; n++) begin
      cyc();
      chk("post_reset_tick", 32'(tick), (n % 4 == 0) ? 32'hF : 32'h0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(9) == 0) en = 4'($urandom);
      if ($urandom_range(3) == 0) write_cfg(2'($urandom), 8'($urandom_range(7)), 1'($urandom));
      if ($urandom_range(29) == 0) sy = 1;
      rst = ($urandom_range(99) == 0);
      cyc();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
